// File: rtl/level_window_ctrl.sv
// Windowed |sample - midscale| accumulator with peak-hold and linear decay.
// Emits one 20-bit level word per window, with a one-cycle valid strobe, to the bar scaler.
module level_window_ctrl #(
    parameter int SAMPLE_W     = 12,
    parameter int MIDSCALE     = 2048,
    parameter int WINDOW       = 16,
    parameter int HOLD_WINDOWS = 4,
    parameter int DECAY_STEP   = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic [19:0]         level_out,
    output logic                level_valid,
    output logic                busy
);
    localparam int CNT_W  = $clog2(WINDOW);
    localparam int HOLD_W = (HOLD_WINDOWS > 0) ? $clog2(HOLD_WINDOWS + 1) : 1;
    localparam logic [SAMPLE_W-1:0] MID       = SAMPLE_W'(MIDSCALE);
    localparam logic [CNT_W-1:0]    LAST      = CNT_W'(WINDOW - 1);
    localparam logic [HOLD_W-1:0]   HOLD_INIT = HOLD_W'(HOLD_WINDOWS);
    localparam logic [19:0]         DECAY     = 20'(DECAY_STEP);

    typedef enum logic [1:0] {IDLE, ACCUM, UPDATE} state_t;

    state_t              state;
    logic [19:0]         acc;
    logic [19:0]         win_sum;
    logic [CNT_W-1:0]    cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [SAMPLE_W-1:0] mag;
    logic [20:0]         sum_wide;
    logic [19:0]         sum_sat;

    // The extra carry bit lets the accumulator clamp at full scale instead of wrapping.
    always_comb begin
        mag      = (sample_in >= MID) ? sample_in - MID : MID - sample_in;
        sum_wide = {1'b0, acc} + 21'(mag);
        sum_sat  = sum_wide[20] ? 20'hFFFFF : sum_wide[19:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            win_sum     <= '0;
            level_out   <= '0;
            level_valid <= 1'b0;
            busy        <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            level_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= ACCUM;
                        busy  <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        acc   <= '0;
                        cnt   <= '0;
                    end else if (sample_valid) begin
                        if (cnt == LAST) begin
                            win_sum <= sum_sat;
                            acc     <= '0;
                            cnt     <= '0;
                            state   <= UPDATE;
                        end else begin
                            acc <= sum_sat;
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                UPDATE: begin
                    // A new peak restarts the hold; otherwise hold runs out before decay begins.
                    if (win_sum >= level_out) begin
                        level_out <= win_sum;
                        hold_cnt  <= HOLD_INIT;
                    end else if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end else begin
                        level_out <= (level_out > DECAY) ? level_out - DECAY : '0;
                    end
                    level_valid <= 1'b1;
                    state       <= enable ? ACCUM : IDLE;
                    busy        <= enable;
                    // A strobe landing here opens the next window rather than being lost.
                    if (enable && sample_valid) begin
                        acc <= 20'(mag);
                        cnt <= CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
